// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sine/cosine core and its wrappers.
//   FRAC_BITS / ONE : Q2.14 fixed-point format of the core's sin/cos results.
//   DEG_WRAP        : one revolution in degrees.
//   ST_*            : state encoding of the sweep sequencer.
//   deg_wrap()      : folds a degree value in 0..719 back into 0..359.
package cordic_pkg;

    localparam int                FRAC_BITS = 14;
    localparam logic signed [15:0] ONE      = 16'sh4000;
    localparam logic [9:0]        DEG_WRAP  = 10'd360;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LAUNCH  = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_SCALE   = 3'd3;
    localparam logic [2:0] ST_PRESENT = 3'd4;
    localparam logic [2:0] ST_ADVANCE = 3'd5;

    // Inputs never exceed 2*359, so a single conditional subtract suffices.
    function automatic logic [8:0] deg_wrap(input logic [9:0] deg);
        logic [9:0] red;
        red = (deg >= DEG_WRAP) ? (deg - DEG_WRAP) : deg;
        return red[8:0];
    endfunction

endpackage

// File: rtl/cordic_pt_scale.sv
// One axis of the point transform: ctr + round(radius * trig / 2^14).
//   radius : unsigned 8-bit scale factor.
//   trig   : signed Q2.14 sine or cosine.
//   ctr    : signed centre offset, W_OUT bits.
//   pt     : signed result, wraps modulo 2^W_OUT (no saturation).
// Purely combinational; the caller registers the result.
module cordic_pt_scale
    import cordic_pkg::*;
#(
    parameter int W_OUT = 16
) (
    input  logic [7:0]       radius,
    input  logic [15:0]      trig,
    input  logic [W_OUT-1:0] ctr,
    output logic [W_OUT-1:0] pt
);

    logic signed [24:0]            prod;
    logic signed [24:0]            prod_rnd;
    logic signed [24-FRAC_BITS:0]  term;
    logic signed [W_OUT-1:0]       term_ext;

    always_comb begin
        // radius is zero-extended to 9 bits so the product is a signed 25-bit value.
        prod     = $signed({1'b0, radius}) * $signed(trig);
        // Add half an LSB of the output, then drop the fraction: round half up.
        prod_rnd = prod + 25'(ONE >>> 1);
        term     = prod_rnd[24:FRAC_BITS];
        term_ext = W_OUT'(term);
        pt       = ctr + term_ext;
    end

endmodule

// File: rtl/cordic_sweep_ctrl.sv
// Angle-sweep sequencer around the CORDIC sine/cosine core.
// Steps an angle in degrees, launches the core, waits for a fresh rising edge
// of its done level, scales sin/cos by a radius about a centre point and
// presents one (x, y) point per angle on a valid/ready stream.
//   clk, reset         : clock, asynchronous active-high reset.
//   sweep_en           : level, starts/continues a sweep.
//   one_shot           : stop after one revolution (sampled at sweep start).
//   start_angle, step  : first angle and increment in degrees (sampled at start).
//   radius, cx, cy     : scale and centre (sampled at start).
//   cs_angle/cs_start  : angle and one-cycle launch pulse to the core.
//   cs_done/cs_sin/cs_cos : core completion level and Q2.14 results.
//   pt_x/pt_y/pt_valid/pt_ready : output point stream.
//   sweep_done         : pulse when a one-shot revolution completes.
//   err                : pulse when the core fails to finish within TIMEOUT cycles.
module cordic_sweep_ctrl
    import cordic_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int W_OUT   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sweep_en,
    input  logic             one_shot,
    input  logic [8:0]       start_angle,
    input  logic [8:0]       step,
    input  logic [7:0]       radius,
    input  logic [W_OUT-1:0] cx,
    input  logic [W_OUT-1:0] cy,
    output logic [15:0]      cs_angle,
    output logic             cs_start,
    input  logic             cs_done,
    input  logic [15:0]      cs_sin,
    input  logic [15:0]      cs_cos,
    output logic [W_OUT-1:0] pt_x,
    output logic [W_OUT-1:0] pt_y,
    output logic             pt_valid,
    input  logic             pt_ready,
    output logic             sweep_done,
    output logic             err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [2:0]       state_q, state_d;
    logic [8:0]       angle_q, angle_d;
    logic [8:0]       step_q, step_d;
    logic [8:0]       acc_q, acc_d;
    logic             one_shot_q, one_shot_d;
    logic [7:0]       radius_q, radius_d;
    logic [W_OUT-1:0] cx_q, cx_d;
    logic [W_OUT-1:0] cy_q, cy_d;
    logic [15:0]      sin_q, sin_d;
    logic [15:0]      cos_q, cos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [W_OUT-1:0] pt_x_q, pt_x_d;
    logic [W_OUT-1:0] pt_y_q, pt_y_d;

    logic             done_rise;
    logic             timeout_hit;
    logic             rev_complete;
    logic [9:0]       angle_sum;
    logic [9:0]       acc_sum;
    logic [W_OUT-1:0] scaled_x;
    logic [W_OUT-1:0] scaled_y;

    cordic_pt_scale #(.W_OUT(W_OUT)) u_scale_x (
        .radius (radius_q),
        .trig   (cos_q),
        .ctr    (cx_q),
        .pt     (scaled_x)
    );

    cordic_pt_scale #(.W_OUT(W_OUT)) u_scale_y (
        .radius (radius_q),
        .trig   (sin_q),
        .ctr    (cy_q),
        .pt     (scaled_y)
    );

    // done_q tracks cs_done every cycle, so a level still high from the
    // previous operation is already recorded and never looks like a new edge.
    assign done_rise    = cs_done & ~done_q;
    assign timeout_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign angle_sum    = {1'b0, angle_q} + {1'b0, step_q};
    assign acc_sum      = {1'b0, acc_q} + {1'b0, step_q};
    assign rev_complete = one_shot_q && (acc_sum >= DEG_WRAP);

    always_comb begin
        state_d    = state_q;
        angle_d    = angle_q;
        step_d     = step_q;
        acc_d      = acc_q;
        one_shot_d = one_shot_q;
        radius_d   = radius_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        sin_d      = sin_q;
        cos_d      = cos_q;
        cnt_d      = cnt_q;
        done_d     = cs_done;
        pt_x_d     = pt_x_q;
        pt_y_d     = pt_y_q;

        case (state_q)
            ST_IDLE: begin
                if (sweep_en) begin
                    one_shot_d = one_shot;
                    angle_d    = deg_wrap({1'b0, start_angle});
                    step_d     = (step == 9'd0) ? 9'd1 : step;
                    acc_d      = 9'd0;
                    radius_d   = radius;
                    cx_d       = cx;
                    cy_d       = cy;
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done edge takes priority over a coincident timeout.
                if (done_rise) begin
                    sin_d   = cs_sin;
                    cos_d   = cs_cos;
                    state_d = ST_SCALE;
                end else if (timeout_hit) begin
                    state_d = ST_LAUNCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SCALE: begin
                pt_x_d  = scaled_x;
                pt_y_d  = scaled_y;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (pt_ready) begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                angle_d = deg_wrap(angle_sum);
                acc_d   = acc_sum[8:0];
                if (rev_complete || !sweep_en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            angle_q    <= '0;
            step_q     <= 9'd1;
            acc_q      <= '0;
            one_shot_q <= 1'b0;
            radius_q   <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            sin_q      <= '0;
            cos_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            pt_x_q     <= '0;
            pt_y_q     <= '0;
        end else begin
            state_q    <= state_d;
            angle_q    <= angle_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            one_shot_q <= one_shot_d;
            radius_q   <= radius_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            sin_q      <= sin_d;
            cos_q      <= cos_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            pt_x_q     <= pt_x_d;
            pt_y_q     <= pt_y_d;
        end
    end

    assign cs_angle   = {7'd0, angle_q};
    assign cs_start   = (state_q == ST_LAUNCH);
    assign err        = (state_q == ST_WAIT) && timeout_hit && !done_rise;
    assign sweep_done = (state_q == ST_ADVANCE) && rev_complete;
    assign pt_valid   = (state_q == ST_PRESENT);
    assign pt_x       = pt_x_q;
    assign pt_y       = pt_y_q;

endmodule

// File: doc/cordic_sweep_ctrl.md
# cordic_sweep_ctrl

Angle-sweep sequencer wrapped around the CORDIC sine/cosine core. It generates the degree angle sequence, pulses `start`, and detects completion on the core's level `done`. It then scales the Q2.14 sine/cosine results by a radius and offsets them to a centre point, emitting one (x, y) point per angle on a valid/ready stream. The downstream consumer is the pixel/plot stage.

## Interface
Parameters:
- `TIMEOUT`, default 64: cycles allowed between `cs_start` and a rising `cs_done` before the error path is taken.
- `W_OUT`, default 16: width of the signed output coordinates.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sweep_en`  in  1  level; high starts or continues a sweep.
- `one_shot`  in  1  1 = stop after one revolution; 0 = continuous. Sampled at sweep start.
- `start_angle`  in  9  first angle, degrees 0..359 (values ≥360 reduced by 360). Sampled at sweep start.
- `step`  in  9  angle increment, degrees 1..359 (0 treated as 1). Sampled at sweep start.
- `radius`  in  8  unsigned scale factor.
- `cx`, `cy`  in  W_OUT  signed centre offsets.
- `cs_angle`  out  16  angle to the core, zero-extended degrees.
- `cs_start`  out  1  one-cycle launch pulse.
- `cs_done`  in  1  core done level.
- `cs_sin`, `cs_cos`  in  16  signed Q2.14 results.
- `pt_x`, `pt_y`  out  W_OUT  signed point.
- `pt_valid`  out  1  point available.
- `pt_ready`  in  1  consumer accept.
- `sweep_done`  out  1  one-cycle pulse when a one-shot revolution completes.
- `err`  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE, LAUNCH, WAIT, SCALE, PRESENT, ADVANCE.
- IDLE:
  - If `sweep_en`=1, latch `one_shot`, `start_angle` (mod 360) and `step` (0→1).
  - Load the current angle and clear the 9-bit degree accumulator `acc`.
  - Go to LAUNCH.
- LAUNCH: drive `cs_start`=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - Keep a registered copy of `cs_done` and detect its 0→1 edge. The level still held high from a previous operation is never accepted.
  - On the edge, capture `cs_sin` and `cs_cos`, then go to SCALE.
  - If the counter reaches `TIMEOUT` first: pulse `err`, then go to LAUNCH with the same angle.
- SCALE (one registered cycle):
  - `px = cx + ((zext(radius) * cs_cos + 2^13) >>> 14)`.
  - `py = cy + ((zext(radius) * cs_sin + 2^13) >>> 14)`.
  - Products are 25-bit signed. The scaled term is sign-extended to W_OUT. Addition wraps modulo 2^W_OUT with no saturation.
  - Go to PRESENT.
- PRESENT:
  - `pt_valid`=1 with `pt_x`/`pt_y` stable.
  - Transfer occurs on `pt_valid & pt_ready`, then go to ADVANCE.
  - While `pt_ready`=0, hold valid and data unchanged. No new launch occurs.
- ADVANCE:
  - Next angle = angle + step; if the sum is ≥360, subtract 360.
  - `acc += step`.
  - If `one_shot` and `acc` ≥ 360: pulse `sweep_done`, go to IDLE.
  - Else if `sweep_en`=0: go to IDLE.
  - Else: go to LAUNCH.
- Dropping `sweep_en` mid-point does not abort. The in-flight point completes and is delivered first.
- Configuration inputs change only in IDLE. Changes in other states are ignored.

## Timing
- Reset values:
  - State IDLE.
  - `cs_start`=0, `cs_angle`=0, `pt_valid`=0, `pt_x`=`pt_y`=0, `sweep_done`=0, `err`=0.
  - `acc`=0; done-edge register=0.
- `reset` during any state returns to IDLE asynchronously. A pending point is discarded. The core is reset by the same signal.
- `cs_angle` is valid from the LAUNCH cycle and stays stable through WAIT.
- Point latency: IDLE→LAUNCH (1), WAIT (N = core latency + 1 for edge detect), SCALE (1). `pt_valid` rises on the cycle after SCALE.
- Best-case point period with `pt_ready` tied high: N + 4 cycles.
- `sweep_done` and `err` are single-cycle pulses. `err` and a done edge in the same cycle: the done edge wins.

## Structure
- Shared package `cordic_pkg`:
  - Q2.14 format constants (`FRAC_BITS`=14, `ONE`=16'h4000).
  - The 360 wrap constant.
  - The state enum for this block.
- Natural sub-module `cordic_pt_scale`: a combinational multiply-round-offset for one axis, instantiated twice.

## Test plan
- Reset, then `sweep_en`=1, `start_angle`=0, `step`=90, `one_shot`=1, r=100, cx=cy=128. Bench core model returns exact Q2.14 values.
  - Required: points (228,128), (128,228), (28,128), (128,28) at angles 0/90/180/270.
  - Then one `sweep_done` pulse and return to IDLE.
- Wrap: `start_angle`=350, `step`=20, continuous.
  - Required: `cs_angle` sequence 350, 10, 30, 50; never ≥360.
- Stale done: hold `cs_done`=1 from the previous op; the model drops it 2 cycles after start and raises it 32 cycles later.
  - Required: capture happens only after that rise.
- Timeout: `cs_done` never toggles, `TIMEOUT`=64.
  - Required: `err` pulses 64 cycles after `cs_start`; relaunch at the same angle.
- Backpressure: `pt_ready`=0 for 10 cycles at the 45° point (r=255, cos=sin=0x2D41).
  - Required: `pt_valid` held, `pt_x`=`pt_y`=308 stable, no `cs_start` until accepted.
- Reset asserted in WAIT.
  - Required: all outputs at reset values immediately; a restart begins at `start_angle`.
